// File: rtl/sha1_wb_seq.sv
// sha1_wb_seq: Wishbone master that streams one 512-bit block into a sha1_wb
// peripheral, waits for done, reads the digest back and emits it h0 first.
// Optional watchdog: define SHA1_SEQ_TIMEOUT_EN to fault on a stalled WAIT or
// a bus access that is never acknowledged.
module sha1_wb_seq #(
  parameter logic [31:0] BASE_ADDRESS   = 32'h30000024,
  parameter int          TIMEOUT_CYCLES = 4096
) (
  input  logic        wb_clk_i,
  input  logic        reset,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  input  logic        sha1_done,
  output logic        busy,
  output logic        error,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i
);

  localparam logic [31:0] ADR_OPS = BASE_ADDRESS + 32'h8;
  localparam logic [31:0] ADR_MSG = BASE_ADDRESS + 32'hC;
  localparam logic [31:0] ADR_DIG = BASE_ADDRESS + 32'h10;
  localparam logic [31:0] EBUSY   = 32'hFFFFFFF0;

  typedef enum logic [3:0] {
    S_IDLE, S_CLR, S_LOAD, S_WAIT, S_READ, S_EMIT, S_OFF, S_FAULT, S_ERROR
  } state_t;

  state_t      state;
  logic [3:0]  n_cnt;
  logic [2:0]  k_cnt;
  logic [2:0]  idx;
  logic [31:0] dig [0:4];
  logic        timeout;

  assign wbm_sel_o = 4'hF;
  assign busy      = (state != S_IDLE) && (state != S_ERROR);
  assign error     = (state == S_ERROR);

`ifdef SHA1_SEQ_TIMEOUT_EN
  logic [15:0] wd_cnt;
  state_t      state_prev;
  logic        wd_run;

  assign wd_run  = (state == S_WAIT) || (wbm_stb_o && !wbm_ack_i);
  // The first cycle after a state change reads wd_cnt as stale, hence the
  // -2 offset so the fault lands exactly TIMEOUT_CYCLES cycles after entry.
  assign timeout = wd_run && (state == state_prev) &&
                   (wd_cnt >= 16'(TIMEOUT_CYCLES - 2));

  // Watchdog: count WAIT cycles and unacknowledged strobe cycles.
  always_ff @(posedge wb_clk_i) begin
    if (reset) begin
      wd_cnt     <= 16'd0;
      state_prev <= S_IDLE;
    end else begin
      state_prev <= state;
      if ((state != state_prev) || (wbm_stb_o && wbm_ack_i))
        wd_cnt <= 16'd0;
      else if (wd_run)
        wd_cnt <= wd_cnt + 16'd1;
    end
  end
`else
  logic unused_timeout_param;
  assign unused_timeout_param = (TIMEOUT_CYCLES == 0);
  assign timeout = 1'b0;
`endif

  // Sequencer FSM: owns the bus master, the input/output handshakes and the
  // digest buffer. A bus access ends on the edge that samples ack with stb
  // high; stb is then low for the following cycle before any new access.
  always_ff @(posedge wb_clk_i) begin
    if (reset) begin
      state     <= S_IDLE;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_adr_o <= 32'h0;
      wbm_dat_o <= 32'h0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= 32'h0;
      n_cnt     <= 4'd0;
      k_cnt     <= 3'd0;
      idx       <= 3'd0;
    end else if (timeout) begin
      // A stall while already cleaning up cannot be retried, so give up.
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      state     <= (state == S_FAULT) ? S_ERROR : S_FAULT;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) state <= S_CLR;
        end
        S_CLR: begin
          if (!wbm_stb_o) begin
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_we_o  <= 1'b1;
            wbm_adr_o <= ADR_OPS;
            wbm_dat_o <= 32'h2;
          end else if (wbm_ack_i) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            n_cnt     <= 4'd0;
            state     <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (wbm_stb_o) begin
            if (wbm_ack_i) begin
              wbm_cyc_o <= 1'b0;
              wbm_stb_o <= 1'b0;
              if (wbm_dat_i != 32'h1) state <= S_FAULT;
              else if (n_cnt == 4'd15) state <= S_WAIT;
              else n_cnt <= n_cnt + 4'd1;
            end
          end else if (in_ready) begin
            if (in_valid) begin
              in_ready  <= 1'b0;
              wbm_cyc_o <= 1'b1;
              wbm_stb_o <= 1'b1;
              wbm_we_o  <= 1'b1;
              wbm_adr_o <= ADR_MSG;
              wbm_dat_o <= in_data;
            end
          end else begin
            in_ready <= 1'b1;
          end
        end
        S_WAIT: begin
          if (sha1_done) begin
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_we_o  <= 1'b0;
            wbm_adr_o <= ADR_DIG;
            k_cnt     <= 3'd0;
            state     <= S_READ;
          end
        end
        S_READ: begin
          if (!wbm_stb_o) begin
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_we_o  <= 1'b0;
            wbm_adr_o <= ADR_DIG;
          end else if (wbm_ack_i) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            if (wbm_dat_i == EBUSY) begin
              state <= S_FAULT;
            end else begin
              // Slave returns h4 first, so the last read is h0.
              dig[3'd4 - k_cnt] <= wbm_dat_i;
              if (k_cnt == 3'd4) begin
                out_data  <= wbm_dat_i;
                out_valid <= 1'b1;
                out_last  <= 1'b0;
                idx       <= 3'd0;
                state     <= S_EMIT;
              end else begin
                k_cnt <= k_cnt + 3'd1;
              end
            end
          end
        end
        S_EMIT: begin
          if (out_valid && out_ready) begin
            if (idx == 3'd4) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              state     <= S_OFF;
            end else begin
              idx      <= idx + 3'd1;
              out_data <= dig[idx + 3'd1];
              out_last <= (idx == 3'd3);
            end
          end
        end
        S_OFF, S_FAULT: begin
          if (!wbm_stb_o) begin
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_we_o  <= 1'b1;
            wbm_adr_o <= ADR_OPS;
            wbm_dat_o <= (state == S_OFF) ? 32'h0 : 32'h2;
          end else if (wbm_ack_i) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            state     <= (state == S_OFF) ? S_IDLE : S_ERROR;
          end
        end
        S_ERROR: begin
          in_ready <= 1'b0;
        end
        default: state <= S_ERROR;
      endcase
    end
  end

endmodule

// File: tb/tb_sha1_wb_seq.sv
// tb_sha1_wb_seq: randomized bench for sha1_wb_seq with a sha1_wb slave model
// and a transaction-level reference of the expected bus log and output stream.
module tb_sha1_wb_seq;

  localparam logic [31:0] BASE = 32'h30000024;
  localparam logic [31:0] OPS  = BASE + 32'h8;
  localparam logic [31:0] MSG  = BASE + 32'hC;
  localparam logic [31:0] DIG  = BASE + 32'h10;

  logic        wb_clk_i, reset;
  logic [31:0] in_data;
  logic        in_valid, in_ready;
  logic [31:0] out_data;
  logic        out_valid, out_ready, out_last;
  logic        sha1_done;
  logic        busy, error;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic        wbm_ack_i;

  sha1_wb_seq #(.BASE_ADDRESS(BASE), .TIMEOUT_CYCLES(100)) dut (
    .wb_clk_i(wb_clk_i), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .sha1_done(sha1_done), .busy(busy), .error(error),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Slave model configuration and state
  logic [31:0] msg  [16];
  logic [31:0] digv [5];
  int          fault_msg_idx = -1;
  int          fault_rd_idx  = -1;
  int          done_delay    = 200;
  logic        clr_model     = 1'b0;
  logic [95:0] log_q [$];
  logic [95:0] exp_q [$];
  int          m_wr = 0, m_rd = 0, done_tmr = 0;
  int          prot_err = 0;
  logic        abort = 1'b0;
  logic [31:0] rx_data [5];
  logic        rx_last [5];

  initial begin
    wbm_ack_i = 1'b0;
    wbm_dat_i = 32'h0;
    sha1_done = 1'b0;
  end

  // sha1_wb slave: registered ack repeating while stb is held, bus log, done timer
  always @(posedge wb_clk_i) begin
    wbm_ack_i <= wbm_cyc_o & wbm_stb_o;
    if (wbm_cyc_o && wbm_stb_o) begin
      if (wbm_we_o)
        wbm_dat_i <= (wbm_adr_o == MSG && m_wr == fault_msg_idx) ? 32'h0FFFFFEA : 32'h1;
      else if (m_rd == fault_rd_idx)
        wbm_dat_i <= 32'hFFFFFFF0;
      else
        wbm_dat_i <= (m_rd >= 0 && m_rd < 5) ? digv[4 - m_rd] : 32'h0;
    end
    if (clr_model) begin
      log_q.delete();
      m_wr      <= 0;
      m_rd      <= 0;
      done_tmr  <= 0;
      sha1_done <= 1'b0;
    end else begin
      if (done_tmr > 0) begin
        done_tmr <= done_tmr - 1;
        if (done_tmr == 1) sha1_done <= 1'b1;
      end
      if (wbm_cyc_o && wbm_stb_o && wbm_ack_i) begin
        log_q.push_back({31'b0, wbm_we_o, wbm_adr_o, wbm_we_o ? wbm_dat_o : 32'h0});
        if (wbm_we_o && wbm_adr_o == MSG) begin
          m_wr <= m_wr + 1;
          if (m_wr == 15 && done_delay > 0) done_tmr <= done_delay;
        end
        if (!wbm_we_o && wbm_adr_o == DIG) m_rd <= m_rd + 1;
        if (wbm_we_o && wbm_adr_o == OPS) sha1_done <= 1'b0;
      end
    end
  end

  logic        p_stb = 1'b0, p_ack = 1'b0, p_we = 1'b0, p_rst = 1'b1;
  logic [31:0] p_adr = 32'h0, p_dat = 32'h0;

  // Bus protocol monitor: stable while waiting, drop after ack, cyc==stb, sel=F
  always @(posedge wb_clk_i) begin
    if (!p_rst && !reset) begin
      if (p_stb && !p_ack &&
          !(wbm_stb_o && wbm_adr_o == p_adr && wbm_we_o == p_we && (!p_we || wbm_dat_o == p_dat)))
        prot_err <= prot_err + 1;
      if (p_stb && p_ack && wbm_stb_o) prot_err <= prot_err + 1;
      if (wbm_cyc_o != wbm_stb_o || wbm_sel_o != 4'hF) prot_err <= prot_err + 1;
    end
    p_stb <= wbm_stb_o; p_ack <= wbm_ack_i; p_we <= wbm_we_o;
    p_adr <= wbm_adr_o; p_dat <= wbm_dat_o; p_rst <= reset;
  end

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge wb_clk_i);
    #1 reset = 1'b0;
  endtask

  task automatic clr_pulse();
    clr_model = 1'b1;
    @(posedge wb_clk_i);
    #1 clr_model = 1'b0;
  endtask

  // Reference bus log: OPS<-2, the message words, digest reads, final OPS write
  function automatic void build_exp(input int nmsg, input int nrd, input logic [31:0] last_ops);
    exp_q.delete();
    exp_q.push_back({31'b0, 1'b1, OPS, 32'h2});
    for (int i = 0; i < nmsg; i++) exp_q.push_back({31'b0, 1'b1, MSG, msg[i]});
    for (int j = 0; j < nrd; j++) exp_q.push_back({31'b0, 1'b0, DIG, 32'h0});
    exp_q.push_back({31'b0, 1'b1, OPS, last_ops});
  endfunction

  task automatic compare_log(input string name);
    chk($sformatf("%s_log_len", name), log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s_log%0d", name, i), (i < log_q.size()) ? log_q[i] : 96'h0, exp_q[i]);
  endtask

  task automatic feed(input int nwords, input int bound, input int gapmax, output int sent);
    bit ok;
    sent = 0;
    for (int i = 0; i < nwords && !abort; i++) begin
      int gap;
      gap = $urandom_range(gapmax, 0);
      if (gap > 0) begin
        repeat (gap) @(posedge wb_clk_i);
        #1;
      end
      in_data  = msg[i];
      in_valid = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < bound && !abort; c++) begin
        @(negedge wb_clk_i);
        if (in_ready) begin
          @(posedge wb_clk_i);
          #1;
          ok = 1'b1;
          break;
        end
      end
      in_valid = 1'b0;
      if (!ok) break;
      sent++;
    end
  endtask

  task automatic drain(input int bound, input bit bp, output int got);
    bit held;
    held = 1'b0;
    got  = 0;
    for (int c = 0; c < bound && got < 5; c++) begin
      if (bp && got == 1 && !held) begin
        held = 1'b1;
        out_ready = 1'b0;
        for (int w = 0; w < bound; w++) begin
          @(negedge wb_clk_i);
          if (out_valid) break;
        end
        for (int j = 0; j < 10; j++) begin
          @(negedge wb_clk_i);
          chk($sformatf("bp_hold%0d", j), {out_valid, out_last, out_data}, {1'b1, 1'b0, digv[1]});
        end
        @(posedge wb_clk_i);
        #1;
      end
      out_ready = bp ? 1'b1 : ($urandom_range(3, 0) != 0);
      @(negedge wb_clk_i);
      if (out_valid && out_ready) begin
        rx_data[got] = out_data;
        rx_last[got] = out_last;
        got++;
      end
      @(posedge wb_clk_i);
      #1;
    end
    out_ready = 1'b0;
  endtask

  task automatic run_job(input string name, input bit bp, input int gapmax);
    int sent, got;
    clr_pulse();
    fork
      feed(16, 3000, gapmax, sent);
      drain(4000, bp, got);
    join
    repeat (10) @(posedge wb_clk_i);
    #1;
    chk({name, "_sent"}, sent, 16);
    chk({name, "_got"}, got, 5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("%s_out%0d", name, i), {rx_last[i], rx_data[i]}, {(i == 4), digv[i]});
    build_exp(16, 5, 32'h0);
    compare_log(name);
    chk({name, "_idle"}, {busy, error, in_ready, out_valid, wbm_cyc_o}, 5'b0);
    chk({name, "_prot"}, prot_err, 0);
  endtask

  task automatic rand_data();
    for (int i = 0; i < 16; i++) msg[i] = $urandom;
    for (int i = 0; i < 5; i++) begin
      digv[i] = $urandom;
      if (digv[i] == 32'hFFFFFFF0) digv[i] = 32'h0;
    end
  endtask

  initial begin
    int sent, inr, lsz;
    bit found;
    reset = 1'b1; in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b0;
    repeat (3) @(posedge wb_clk_i);
    #1;
    chk("rst_bus", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o}, 7'h0F);
    chk("rst_adr_dat", {wbm_adr_o, wbm_dat_o}, 64'h0);
    chk("rst_stream", {in_ready, out_valid, out_last, out_data}, 35'h0);
    chk("rst_status", {busy, error}, 2'b00);
    reset = 1'b0;

    // Fixed message from the reference block, known digest words
    for (int i = 0; i < 16; i++) msg[i] = 32'h0;
    msg[0] = 32'h61626380; msg[15] = 32'h00000018;
    digv[0] = 32'h11111111; digv[1] = 32'h22222222; digv[2] = 32'h33333333;
    digv[3] = 32'h44444444; digv[4] = 32'h55555555;
    done_delay = 200;
    run_job("basic", 1'b0, 0);

    for (int r = 0; r < 3; r++) begin
      rand_data();
      done_delay = $urandom_range(60, 5);
      run_job($sformatf("rand%0d", r), 1'b0, 3);
    end

    rand_data();
    done_delay = 30;
    run_job("bp", 1'b1, 0);

    // Bad response on the 3rd MSG_IN write
    rand_data();
    fault_msg_idx = 2;
    clr_pulse();
    feed(16, 300, 0, sent);
    chk("mfault_sent", sent, 3);
    lsz = log_q.size();
    inr = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge wb_clk_i);
      if (in_ready) inr++;
    end
    chk("mfault_quiet", {log_q.size(), inr}, {lsz, 32'd0});
    chk("mfault_status", {error, busy}, 2'b10);
    build_exp(3, 0, 32'h2);
    compare_log("mfault");
    chk("mfault_prot", prot_err, 0);
    fault_msg_idx = -1;
    @(posedge wb_clk_i); #1;
    do_reset();
    chk("mfault_clear", {error, busy}, 2'b00);

    // EBUSY on the first DIGEST read
    rand_data();
    fault_rd_idx = 0;
    done_delay = 20;
    clr_pulse();
    feed(16, 3000, 0, sent);
    chk("dfault_sent", sent, 16);
    found = 1'b0;
    for (int c = 0; c < 500 && !found; c++) begin
      @(negedge wb_clk_i);
      if (error) found = 1'b1;
    end
    chk("dfault_err", {found, busy, out_valid}, 3'b100);
    repeat (5) @(negedge wb_clk_i);
    build_exp(16, 1, 32'h2);
    compare_log("dfault");
    fault_rd_idx = -1;
    @(posedge wb_clk_i); #1;
    do_reset();

    // Reset during the 8th MSG_IN write, then a fresh job
    rand_data();
    clr_pulse();
    found = 1'b0;
    fork
      feed(16, 3000, 0, sent);
      begin
        for (int c = 0; c < 3000 && !found; c++) begin
          @(negedge wb_clk_i);
          if (wbm_stb_o && wbm_adr_o == MSG && m_wr == 7) begin
            found = 1'b1;
            reset = 1'b1;
            abort = 1'b1;
            @(posedge wb_clk_i);
            #1;
            chk("mrst_bus", {wbm_cyc_o, wbm_stb_o, busy, in_ready}, 4'b0);
            @(posedge wb_clk_i);
            #1 reset = 1'b0;
          end
        end
      end
    join
    chk("mrst_found", found, 1'b1);
    abort = 1'b0;
    rand_data();
    done_delay = 25;
    run_job("after_rst", 1'b0, 1);

    // done never arrives
    rand_data();
    done_delay = -1;
    clr_pulse();
    feed(16, 3000, 0, sent);
    repeat (300) @(negedge wb_clk_i);
`ifdef SHA1_SEQ_TIMEOUT_EN
    chk("tmo_status", {error, busy}, 2'b10);
    chk("tmo_log_len", log_q.size(), 18);
`else
    chk("tmo_status", {error, busy}, 2'b01);
    chk("tmo_log_len", log_q.size(), 17);
`endif
    chk("tmo_prot", prot_err, 0);
    @(posedge wb_clk_i); #1;
    do_reset();

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/sha1_wb_seq.md
# sha1_wb_seq

Wishbone master sequencer that drives the `sha1_wb` peripheral through one 512-bit block per job. It takes 16 message words from a valid/ready input stream, programs the peripheral, waits for `done`, and reads back the 160-bit digest. It emits the digest as 5 words on a valid/ready output stream, h0 first. It sits between a DMA/stream source and `sha1_wb` on the user-project Wishbone bus, so firmware no longer has to poll.

## Interface
- `BASE_ADDRESS`, 32'h30000024: base of the target `sha1_wb` register window.
- `TIMEOUT_CYCLES`, 4096: watchdog limit in cycles; 16-bit counter.
- `wb_clk_i` in 1: clock.
- `reset` in 1: reset, synchronous, active-high; clock wb_clk_i.
- `in_data` in 32: message word, big-endian SHA-1 word order.
- `in_valid` in 1 / `in_ready` out 1: input handshake; a transfer occurs when both are high.
- `out_data` out 32: digest word.
- `out_valid` out 1 / `out_ready` in 1: output handshake.
- `out_last` out 1: high with the 5th digest word.
- `sha1_done` in 1: `done` output of `sha1_wb`.
- `busy` out 1: a job is in progress (any state except IDLE and ERROR).
- `error` out 1: sticky fault flag.
- `wbm_cyc_o`, `wbm_stb_o`, `wbm_we_o` out 1: Wishbone master controls.
- `wbm_sel_o` out 4: always 4'hF.
- `wbm_adr_o`, `wbm_dat_o` out 32: address and write data.
- `wbm_dat_i` in 32, `wbm_ack_i` in 1: slave response.

## Operation
- Register offsets used: OPS = BASE+0x8, MSG_IN = BASE+0xC, DIGEST = BASE+0x10.
- States and transitions:
  - IDLE: `in_ready`=0. Go to CLR on `in_valid`; that word is not consumed yet.
  - CLR: write OPS=32'h2 (on=0, engine reset) → LOAD, word count n=0.
  - LOAD: assert `in_ready` for one cycle, latch the word, then write it to MSG_IN.
    - Response must be 32'h1; any other value → FAULT.
    - n increments; after n=15 → WAIT.
  - WAIT: no bus activity. `sha1_done`=1 → READ, k=0.
  - READ: read DIGEST 5 times.
    - Response 32'hFFFFFFF0 (EBUSY) → FAULT.
    - Slave returns h4,h3,h2,h1,h0; store in dig[4-k].
    - After k=4 → EMIT.
  - EMIT: present dig[0..4] in turn; advance on `out_valid`&`out_ready`; `out_last` on index 4. After the last word → OFF.
  - OFF: write OPS=32'h0 → IDLE.
  - FAULT: write OPS=32'h2 → ERROR.
  - ERROR: `error`=1, no bus activity, `in_ready`=0; exits only on `reset`.
- Wishbone rules (slave ack is registered and repeats while stb is held):
  - Raise `cyc`/`stb` together with adr/we/dat, all registered; hold them stable until `wbm_ack_i`=1.
  - On the edge that samples ack=1: capture `wbm_dat_i` and drop `cyc`/`stb`.
  - After that, keep `stb` low for at least one cycle. Do not raise it again while `wbm_ack_i`=1.
  - Ignore `wbm_ack_i` whenever `stb`=0.

## Timing
- Reset values: `wbm_cyc_o`/`stb`/`we`=0, `adr`/`dat_o`=0, `wbm_sel_o`=4'hF, `in_ready`=0, `out_valid`=0, `out_last`=0, `out_data`=0, `busy`=0, `error`=0, state IDLE.
- Reset mid-operation: all of the above apply on the next edge; an in-flight bus cycle is abandoned and buffered words are discarded.
- Bus transaction: stb high on cycles T and T+1 (ack at T+1), stale ack at T+2, next stb no earlier than T+3. Each access therefore costs 3 cycles.
- Input word: `in_ready` pulse at cycle L; bus write starts at L+1.
- `sha1_done` to first DIGEST stb: 1 cycle.
- Last digest ack to `out_valid`: 1 cycle.
- Output back-pressure: `out_data`/`out_last` stay stable while `out_valid`&!`out_ready`.
- `in_valid` low in LOAD: wait indefinitely, with no bus activity.

## Configuration
- `SHA1_SEQ_TIMEOUT_EN` defined: a 16-bit watchdog counts cycles spent in WAIT, and cycles with `stb` high without ack. Reaching `TIMEOUT_CYCLES` → FAULT. The counter clears on each state change and each ack.
- Not defined: no watchdog; WAIT and bus stalls last indefinitely; FAULT is reachable only via bad responses.

## Test plan
The bench uses a `sha1_wb` protocol slave model (registered ack; ack repeats if stb is held).
- Feed 16 words 0x61626380, 0×14, 0x00000018; model asserts done 200 cycles after the 16th write and returns digest reads 0x55555555,0x44444444,0x33333333,0x22222222,0x11111111 → bus log shows OPS←2, 16 MSG_IN writes in order, 5 DIGEST reads, OPS←0. Output is 0x11111111…0x55555555 with `out_last` on the 5th word.
- Model returns 0x0FFFFFEA on the 3rd MSG_IN write → OPS←2, `error`=1, `busy`=0; no further bus cycles or `in_ready`.
- First DIGEST read returns 0xFFFFFFF0 → FAULT path and `error`=1.
- Hold `out_ready`=0 for 10 cycles on word 2 → `out_data` stays stable; all 5 words are delivered in order.
- Assert `reset` during the 8th MSG_IN write → next cycle `cyc`=0, `busy`=0. A fresh job then completes correctly.
- With `SHA1_SEQ_TIMEOUT_EN` and `TIMEOUT_CYCLES`=100, never assert done → FAULT 100 cycles after WAIT entry; without the macro → `busy` stays 1.
